// File: rtl/ascon_pack.sv
// rtl/ascon_pack.sv - shared Ascon state type, round constant, round count and FSM states
package ascon_pack;

  localparam int PA_ROUNDS = 12;

  // s0 occupies the most significant 64 bits, matching the {S0,S1,S2,S3,S4} byte order
  typedef struct packed {
    logic [63:0] s0;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [63:0] s3;
    logic [63:0] s4;
  } type_state;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Round r adds {~r, r} into the low byte of S2 (0xF0 for r=0 ... 0x4B for r=11)
  function automatic logic [7:0] round_const(input logic [3:0] r);
    return {~r, r};
  endfunction

endpackage

// File: rtl/ascon_round.sv
// rtl/ascon_round.sv - one combinational Ascon round: constant add, S-box layer, linear layer
module ascon_round
  import ascon_pack::*;
(
  input  type_state  i_state,
  input  logic [3:0] i_round,
  output type_state  o_state
);

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  logic [63:0] w_x0, w_x1, w_x2, w_x3, w_x4;
  logic [63:0] w_t0, w_t1, w_t2, w_t3, w_t4;

  // Bitsliced 5-bit S-box applied to all 64 columns, then per-word diffusion
  always_comb begin
    w_x0 = i_state.s0;
    w_x1 = i_state.s1;
    w_x2 = i_state.s2 ^ {56'h0, round_const(i_round)};
    w_x3 = i_state.s3;
    w_x4 = i_state.s4;

    w_x0 = w_x0 ^ w_x4;
    w_x4 = w_x4 ^ w_x3;
    w_x2 = w_x2 ^ w_x1;
    w_t0 = ~w_x0 & w_x1;
    w_t1 = ~w_x1 & w_x2;
    w_t2 = ~w_x2 & w_x3;
    w_t3 = ~w_x3 & w_x4;
    w_t4 = ~w_x4 & w_x0;
    w_x0 = w_x0 ^ w_t1;
    w_x1 = w_x1 ^ w_t2;
    w_x2 = w_x2 ^ w_t3;
    w_x3 = w_x3 ^ w_t4;
    w_x4 = w_x4 ^ w_t0;
    w_x1 = w_x1 ^ w_x0;
    w_x0 = w_x0 ^ w_x4;
    w_x3 = w_x3 ^ w_x2;
    w_x2 = ~w_x2;

    o_state.s0 = w_x0 ^ rotr(w_x0, 19) ^ rotr(w_x0, 28);
    o_state.s1 = w_x1 ^ rotr(w_x1, 61) ^ rotr(w_x1, 39);
    o_state.s2 = w_x2 ^ rotr(w_x2, 1)  ^ rotr(w_x2, 6);
    o_state.s3 = w_x3 ^ rotr(w_x3, 10) ^ rotr(w_x3, 17);
    o_state.s4 = w_x4 ^ rotr(w_x4, 7)  ^ rotr(w_x4, 41);
  end

endmodule

// File: rtl/ascon_perm_engine.sv
// rtl/ascon_perm_engine.sv - multi-cycle Ascon p^a/p^b engine, UNROLL rounds per clock; ASCON_PERM_XOR_END_EN enables the end key XOR
module ascon_perm_engine
  import ascon_pack::*;
#(
  parameter int UNROLL    = 1,
  parameter int PB_ROUNDS = 6
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic         mode_i,
  input  logic         src_sel_i,
  input  type_state    state_i,
  input  logic [63:0]  data_i,
  input  logic         bypass_i,
  input  logic [127:0] key_i,
  input  logic         key_begin_i,
  input  logic         key_end_i,
  output logic         busy_o,
  output logic         done_o,
  output type_state    state_o
);

  if ((PA_ROUNDS % UNROLL) != 0 || (PB_ROUNDS % UNROLL) != 0 ||
      (PB_ROUNDS != 6 && PB_ROUNDS != 8)) begin : g_bad_cfg
    $error("ascon_perm_engine: UNROLL must divide 12 and PB_ROUNDS, PB_ROUNDS must be 6 or 8");
  end

  localparam logic [3:0] LP_PB_R0   = 4'(PA_ROUNDS - PB_ROUNDS);
  localparam logic [3:0] LP_UNROLL  = 4'(UNROLL);
  localparam logic [3:0] LP_MAX_CNT = 4'(PA_ROUNDS - 1);

  state_e      r_fsm;
  logic [3:0]  r_cnt;
  type_state   r_state;
  logic        r_busy;
  logic        r_done;

  logic        w_launch;
  logic        w_last;
  logic [3:0]  w_base;
  logic [3:0]  w_next;
  type_state   w_src;
  type_state   w_xb;
  type_state   w_result;
  type_state   w_chain [0:UNROLL];

  assign w_launch = (r_fsm == IDLE) && start_i;
  assign w_base   = w_launch ? (mode_i ? LP_PB_R0 : 4'd0) : r_cnt;
  assign w_next   = w_base + LP_UNROLL;
  assign w_last   = ({1'b0, w_base} + 5'(UNROLL)) == 5'(PA_ROUNDS);

  // Entry stage: pick the source and fold in the data block and begin key
  always_comb begin
    w_src = src_sel_i ? state_i : r_state;
    w_xb  = w_src;
    if (!bypass_i) begin
      w_xb.s0 = w_src.s0 ^ data_i;
    end
    if (key_begin_i) begin
      w_xb.s1 = w_src.s1 ^ key_i[127:64];
      w_xb.s2 = w_src.s2 ^ key_i[63:0];
    end
  end

  assign w_chain[0] = w_launch ? w_xb : r_state;

  for (genvar g = 0; g < UNROLL; g++) begin : g_round
    logic [3:0] w_rnd;
    assign w_rnd = w_base + 4'(g);
    ascon_round u_round (
      .i_state (w_chain[g]),
      .i_round (w_rnd),
      .o_state (w_chain[g+1])
    );
  end

`ifdef ASCON_PERM_XOR_END_EN
  // End key XOR lands in the same edge as the last round
  always_comb begin
    w_result = w_chain[UNROLL];
    if (w_last && key_end_i) begin
      w_result.s3 = w_chain[UNROLL].s3 ^ key_i[127:64];
      w_result.s4 = w_chain[UNROLL].s4 ^ key_i[63:0];
    end
  end
`else
  logic w_unused_key_end;
  assign w_unused_key_end = key_end_i;
  assign w_result         = w_chain[UNROLL];
`endif

  // Control FSM: launch from IDLE, advance the round counter in RUN, pulse done on the final edge
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_fsm   <= IDLE;
      r_cnt   <= 4'd0;
      r_state <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_fsm)
        IDLE: begin
          if (start_i) begin
            r_state <= w_result;
            if (w_last) begin
              r_done <= 1'b1;
              r_cnt  <= 4'd0;
            end else begin
              r_cnt  <= w_next;
              r_fsm  <= RUN;
              r_busy <= 1'b1;
            end
          end
        end
        RUN: begin
          if (r_cnt > LP_MAX_CNT) begin
            r_fsm  <= IDLE;
            r_busy <= 1'b0;
            r_cnt  <= 4'd0;
          end else begin
            r_state <= w_result;
            if (w_last) begin
              r_fsm  <= IDLE;
              r_busy <= 1'b0;
              r_done <= 1'b1;
              r_cnt  <= 4'd0;
            end else begin
              r_cnt <= w_next;
            end
          end
        end
        default: begin
          r_fsm  <= IDLE;
          r_busy <= 1'b0;
          r_cnt  <= 4'd0;
        end
      endcase
    end
  end

  assign busy_o  = r_busy;
  assign done_o  = r_done;
  assign state_o = r_state;

endmodule
